// File: rtl/mult_div_pkg.sv
// ---------------------------------------------------------------------------
// mult_div_pkg
// Shared definitions for the iterative multiply/divide unit:
//   - DEFAULT_WIDTH : default operand width
//   - OP_*          : operation codes carried on the 2-bit op port
//   - md_state_e    : FSM state encoding (also visible on the debug port)
//   - op_is_div / op_is_signed : small decode helpers for the op code
// ---------------------------------------------------------------------------
package mult_div_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;  // signed multiply
  localparam logic [1:0] OP_MULTU = 2'b01;  // unsigned multiply
  localparam logic [1:0] OP_DIV   = 2'b10;  // signed divide
  localparam logic [1:0] OP_DIVU  = 2'b11;  // unsigned divide

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } md_state_e;

  // Bit 1 of the op code selects divide, bit 0 selects unsigned.
  function automatic logic op_is_div(input logic [1:0] code);
    return code[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] code);
    return ~code[0];
  endfunction

endpackage

// File: rtl/md_negate.sv
// ---------------------------------------------------------------------------
// md_negate
// Conditional two's-complement negator. Used to take operand magnitudes
// before the iterative step and to restore result signs afterwards.
// Ports:
//   en     : 1 = output the two's complement of value, 0 = pass through
//   value  : WIDTH-bit input
//   result : WIDTH-bit output
// ---------------------------------------------------------------------------
module md_negate #(
  parameter int WIDTH = 32
) (
  input  logic             en,
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] result
);

  assign result = en ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
// Iterative radix-2 multiply/divide unit (shift-add multiply, restoring
// divide), one step per clock, results in HI/LO registers.
//
// Handshake: start is sampled only when the unit is idle and not busy
// (state IDLE and done low). The accepting edge latches op/src_a/src_b;
// busy is high from the following cycle through the one-cycle done pulse
// inclusive. start while busy is dropped, never queued.
//
// Ports:
//   clock     : rising-edge clock
//   reset     : asynchronous active-low reset
//   start     : operation request
//   op        : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a     : multiplicand / dividend
//   src_b     : multiplier / divisor
//   busy      : operation in flight (includes the done cycle)
//   done      : one-cycle pulse, hi/lo valid
//   div_zero  : sticky divide-by-zero flag, cleared by the next accepted start
//   hi, lo    : result registers (product high/low, or remainder/quotient)
//   fsm_state : debug view of the FSM state
// ---------------------------------------------------------------------------
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [2:0]       fsm_state
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int AW    = 2 * WIDTH + 1;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  md_state_e        state;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [AW-1:0]    acc;       // {upper W+1 bits, lower W bits}
  logic [CNT_W-1:0] count;
  logic             neg_res;   // negate product / quotient in FIX
  logic             neg_rem;   // negate remainder in FIX

  // -------------------------------------------------------------------------
  // Operand magnitudes (only signed ops with a negative operand are negated)
  // -------------------------------------------------------------------------
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  assign a_neg = op_is_signed(op_q) & a_q[WIDTH-1];
  assign b_neg = op_is_signed(op_q) & b_q[WIDTH-1];

  // The most-negative value negates to itself, which read as unsigned is
  // exactly its magnitude, so no special case is needed.
  md_negate #(.WIDTH(WIDTH)) u_abs_a (
    .en     (a_neg),
    .value  (a_q),
    .result (mag_a)
  );

  md_negate #(.WIDTH(WIDTH)) u_abs_b (
    .en     (b_neg),
    .value  (b_q),
    .result (mag_b)
  );

  // -------------------------------------------------------------------------
  // One radix-2 step
  // -------------------------------------------------------------------------
  // Multiply: multiplier sits in the low half; when its LSB is set the
  // multiplicand is added into the upper W+1 bits, then everything shifts
  // right. The upper part never exceeds W+1 bits, so nothing is lost.
  logic [WIDTH:0]  mul_addend;
  logic [WIDTH:0]  mul_sum;
  logic [AW-1:0]   mul_next;

  // Divide: partial remainder in the upper bits, dividend/quotient in the
  // low half. Shift left, trial-subtract the divisor, keep on no borrow and
  // shift a quotient 1 into the LSB.
  logic [AW-1:0]   div_shift;
  logic [WIDTH:0]  div_trial;
  logic            div_fits;
  logic [AW-1:0]   div_next;

  always_comb begin
    mul_addend = '0;
    if (acc[0]) begin
      mul_addend = {1'b0, mag_b};
    end
    mul_sum  = acc[AW-1:WIDTH] + mul_addend;
    mul_next = {1'b0, mul_sum, acc[WIDTH-1:1]};

    div_shift = {acc[AW-2:0], 1'b0};
    div_fits  = (div_shift[AW-1:WIDTH] >= {1'b0, mag_b});
    div_trial = div_shift[AW-1:WIDTH] - {1'b0, mag_b};
    div_next  = div_shift;
    if (div_fits) begin
      div_next = {div_trial, div_shift[WIDTH-1:1], 1'b1};
    end
  end

  // -------------------------------------------------------------------------
  // Sign restoration for FIX
  // -------------------------------------------------------------------------
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  md_negate #(.WIDTH(2 * WIDTH)) u_fix_prod (
    .en     (neg_res),
    .value  (acc[2*WIDTH-1:0]),
    .result (prod_fix)
  );

  md_negate #(.WIDTH(WIDTH)) u_fix_quot (
    .en     (neg_res),
    .value  (acc[WIDTH-1:0]),
    .result (quot_fix)
  );

  md_negate #(.WIDTH(WIDTH)) u_fix_rem (
    .en     (neg_rem),
    .value  (acc[2*WIDTH-1:WIDTH]),
    .result (rem_fix)
  );

  // -------------------------------------------------------------------------
  // Status outputs
  // -------------------------------------------------------------------------
  // done is registered off the DONE state, so the pulse appears while the
  // FSM is already back in IDLE; busy covers that cycle too.
  assign busy      = (state != IDLE) | done;
  assign fsm_state = state;

  // -------------------------------------------------------------------------
  // FSM and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      count    <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= (state == DONE);

      case (state)
        IDLE: begin
          // Ignoring start while done is high keeps the done cycle busy.
          if (start && !done) begin
            op_q     <= op;
            a_q      <= src_a;
            b_q      <= src_b;
            div_zero <= 1'b0;
            state    <= PREP;
          end
        end

        PREP: begin
          neg_res <= a_neg ^ b_neg;
          neg_rem <= a_neg;
          if (op_is_div(op_q) && (b_q == '0)) begin
            div_zero <= 1'b1;
            state    <= DONE;
          end else begin
            acc   <= {{(WIDTH + 1){1'b0}}, mag_a};
            count <= CNT_W'(WIDTH);
            state <= RUN;
          end
        end

        RUN: begin
          acc   <= op_is_div(op_q) ? div_next : mul_next;
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            state <= FIX;
          end
        end

        FIX: begin
          if (op_is_div(op_q)) begin
            hi <= rem_fix;
            lo <= quot_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          state <= DONE;
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
// Directed self-checking bench for mult_div_unit at WIDTH=32. Expected
// results are hand-computed constants pushed onto an expected queue and
// popped when each operation completes.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;
  import mult_div_pkg::*;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op    = 2'b00;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [2:0]   fsm_state;

  int checks = 0;
  int passes = 0;

  logic [2*W-1:0] exp_q[$];

  // -------------------------------------------------------------------------
  // Clock / DUT
  // -------------------------------------------------------------------------
  always #5 clock = ~clock;

  mult_div_unit #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .hi        (hi),
    .lo        (lo),
    .fsm_state (fsm_state)
  );

  // -------------------------------------------------------------------------
  // Comparison
  // -------------------------------------------------------------------------
  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Drivers
  // -------------------------------------------------------------------------
  // Drive a start pulse at the negedge; returns #1 after the accepting edge.
  task automatic issue_start(input logic [1:0] o, input logic [W-1:0] a,
                             input logic [W-1:0] b);
    @(negedge clock);
    op    = o;
    src_a = a;
    src_b = b;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    // Later input changes must not affect the latched operation.
    src_a = W'($urandom);
    src_b = W'($urandom);
    op    = 2'($urandom_range(0, 3));
  endtask

  // Count edges after the accepting edge until done is seen (bounded).
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clock);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp_hilo, input logic exp_dz,
                        input int exp_lat);
    int lat;
    logic [2*W-1:0] exp_v;
    exp_q.push_back(exp_hilo);
    issue_start(o, a, b);
    check({tag, " busy_after_start"}, 64'(busy), 64'(1));
    check({tag, " dz_cleared"}, 64'(div_zero), 64'(0));
    wait_done(lat);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " div_zero"}, 64'(div_zero), 64'(exp_dz));
    exp_v = exp_q.pop_front();
    check({tag, " hi_lo"}, {hi, lo}, exp_v);
    @(posedge clock);
    #1;
    check({tag, " done_one_cycle"}, 64'(done), 64'(0));
    check({tag, " busy_clear"}, 64'(busy), 64'(0));
  endtask

  // -------------------------------------------------------------------------
  // Directed sequence
  // -------------------------------------------------------------------------
  initial begin
    int ndone;
    int first_lat;
    int lat;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("reset busy", 64'(busy), 64'(0));
    check("reset done", 64'(done), 64'(0));
    check("reset div_zero", 64'(div_zero), 64'(0));
    check("reset hi_lo", {hi, lo}, 64'(0));
    check("reset state", 64'(fsm_state), 64'(0));
    @(negedge clock);
    reset = 1'b1;

    // Multiply
    run_op("mult_neg3x5", OP_MULT, 32'hFFFFFFFD, 32'h00000005,
           64'hFFFFFFFF_FFFFFFF1, 1'b0, 35);
    run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
           64'hFFFFFFFE_00000001, 1'b0, 35);
    run_op("mult_m1xm1", OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF,
           64'h00000000_00000001, 1'b0, 35);

    // Divide
    run_op("div_m7d2", OP_DIV, 32'hFFFFFFF9, 32'h00000002,
           64'hFFFFFFFF_FFFFFFFD, 1'b0, 35);
    run_op("div_7dm2", OP_DIV, 32'h00000007, 32'hFFFFFFFE,
           64'h00000001_FFFFFFFD, 1'b0, 35);
    run_op("divu_100d7", OP_DIVU, 32'h00000064, 32'h00000007,
           64'h00000002_0000000E, 1'b0, 35);

    // Divide by zero keeps hi/lo; next start clears the flag
    run_op("multu_set12", OP_MULTU, 32'h80000001, 32'h00000002,
           64'h00000001_00000002, 1'b0, 35);
    run_op("divu_by0", OP_DIVU, 32'h00000064, 32'h00000000,
           64'h00000001_00000002, 1'b1, 2);
    run_op("mult_after_dz", OP_MULT, 32'h00000007, 32'hFFFFFFFE,
           64'hFFFFFFFF_FFFFFFF2, 1'b0, 35);

    // Most-negative / -1
    run_op("div_minneg", OP_DIV, 32'h80000000, 32'hFFFFFFFF,
           64'h00000000_80000000, 1'b0, 35);

    // start pulses while busy and in the done cycle are dropped
    issue_start(OP_MULTU, 32'h00000010, 32'h00000010);
    ndone     = 0;
    first_lat = -1;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clock);
      start = (i == 3) || (i == 20) || (i == 36);
      src_a = W'($urandom);
      src_b = W'($urandom_range(0, 255));
      op    = 2'($urandom_range(0, 3));
      @(posedge clock);
      #1;
      if (done) begin
        ndone++;
        if (first_lat < 0) first_lat = i;
      end
    end
    start = 1'b0;
    check("busy_start done_count", 64'(ndone), 64'(1));
    check("busy_start latency", 64'(first_lat), 64'(35));
    check("busy_start hi_lo", {hi, lo}, 64'h00000000_00000100);
    check("busy_start idle", 64'(busy), 64'(0));

    // Reset 10 cycles into RUN aborts the operation
    issue_start(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (11) @(posedge clock);
    #1;
    check("abort in_run", 64'(fsm_state), 64'(2));
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("abort busy", 64'(busy), 64'(0));
    check("abort done", 64'(done), 64'(0));
    check("abort hi_lo", {hi, lo}, 64'(0));
    check("abort state", 64'(fsm_state), 64'(0));
    repeat (2) @(posedge clock);
    #1;
    check("abort no_done", 64'(done), 64'(0));
    @(negedge clock);
    reset = 1'b1;
    op    = OP_MULT;
    src_a = 32'hFFFFFFFD;
    src_b = 32'h00000005;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    check("post_reset accepted", 64'(busy), 64'(1));
    wait_done(lat);
    check("post_reset latency", 64'(lat), 64'(35));
    check("post_reset hi_lo", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, operand width in bits, legal range 4..64.
REQ-002 Port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-005 Port op, input, 2 bits: operation code, where 00=MULT (signed), 01=MULTU, 10=DIV (signed), 11=DIVU.
REQ-006 Port src_a, input, WIDTH bits: multiplicand or dividend.
REQ-007 Port src_b, input, WIDTH bits: multiplier or divisor.
REQ-008 Port busy, output, 1 bit: high from the cycle after start is accepted until done inclusive.
REQ-009 Port done, output, 1 bit: one-cycle pulse when results are valid.
REQ-010 Port div_zero, output, 1 bit: sticky flag for divide by zero; cleared by the next accepted start.
REQ-011 Port hi, output, WIDTH bits: HI register.
REQ-012 Port lo, output, WIDTH bits: LO register.

Function
REQ-013 FSM states SHALL be IDLE, PREP, RUN, FIX, DONE.
REQ-014 IDLE->PREP on start=1; src_a, src_b and op are latched at that edge, and later input changes are ignored.
REQ-015 PREP: compute operand magnitudes (signed ops only) and record result signs; RUN counter is loaded with WIDTH.
REQ-016 PREP->DONE directly when op is DIV/DIVU and src_b==0: div_zero=1; hi and lo unchanged.
REQ-017 RUN: one radix-2 step per cycle (shift-add multiply; restoring divide); WIDTH cycles; counter decrements, RUN->FIX at count 1.
REQ-018 FIX: negate product if operand signs differ (signed MULT); negate quotient if signs differ and remainder if dividend negative (signed DIV); write hi/lo.
REQ-019 DONE: done=1 for exactly one cycle; DONE->IDLE unconditionally.
REQ-020 Latency: done SHALL be high during the cycle following the (WIDTH+3)th rising edge after the edge sampling start; div-by-zero case: the 2nd edge.
REQ-021 Multiply results: {hi,lo} = full 2*WIDTH-bit product (two's complement for MULT).
REQ-022 Divide results: lo = quotient truncated toward zero, hi = remainder with dividend's sign; |remainder| < |divisor|.
REQ-023 Signed DIV of most-negative by -1: lo = most-negative value, hi = 0; no flag.
REQ-024 start while busy SHALL be ignored (not queued); start asserted in the DONE cycle is ignored; start in the first IDLE cycle is accepted.
REQ-025 hi/lo SHALL change only in FIX and reset; they hold between operations.
REQ-026 Internal accumulator SHALL be 2*WIDTH+1 bits; no truncation before FIX.

Reset
REQ-027 On reset=0, asynchronously: state=IDLE, busy=0, done=0, div_zero=0, hi=0, lo=0, counter=0.
REQ-028 Reset during any non-IDLE state SHALL abort the operation; no done pulse is produced.
REQ-029 The first start after reset release SHALL be accepted on the next rising edge.

Structure
REQ-030 Package mult_div_pkg SHALL hold: op code constants (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), FSM state enumeration, and default WIDTH constant.
REQ-031 A single sub-module md_negate (WIDTH-parameterised conditional two's-complement negator) is natural; it is used in PREP and FIX.
REQ-032 The FSM and datapath SHALL remain in mult_div_unit; no multipliers/dividers (* / %) are inferred.

Verification (WIDTH=32)
REQ-033 MULT src_a=FFFFFFFD, src_b=00000005 -> hi=FFFFFFFF, lo=FFFFFFF1, done 35 edges after start.
REQ-034 MULTU FFFFFFFF x FFFFFFFF -> hi=FFFFFFFE, lo=00000001; the same operands with MULT -> hi=00000000, lo=00000001.
REQ-035 DIV FFFFFFF9 / 00000002 -> lo=FFFFFFFD, hi=FFFFFFFF; DIVU 00000064 / 00000007 -> lo=0000000E, hi=00000002.
REQ-036 DIVU 00000064 / 00000000 with prior hi=1, lo=2 -> div_zero=1, done after 2 edges, hi=1, lo=2; the next MULT start clears div_zero.
REQ-037 DIV 80000000 / FFFFFFFF -> lo=80000000, hi=00000000, div_zero=0.
REQ-038 Assert reset 10 cycles into RUN -> busy=0, hi=lo=0, no done; a start on the first edge after release completes normally; start pulses while busy produce no extra done.
